// File: rtl/sfifo_rd_pkg.sv
// Shared types and helpers for the synchronous-FIFO read-stream controller.
package sfifo_rd_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_e;

    // A burst of one beat still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sfifo_rd_skid.sv
// Two-entry output stage (main + skid): absorbs the one word already in flight
// when downstream stalls, so the FIFO read enable never depends on m_ready.
module sfifo_rd_skid
    import sfifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  skid_valid
);

    logic                  main_valid_q, main_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
    logic                  main_last_q,  main_last_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic                  skid_last_q,  skid_last_d;

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;

        if (clear) begin
            main_valid_d = 1'b0;
            main_data_d  = '0;
            main_last_d  = 1'b0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
            skid_last_d  = 1'b0;
        end else begin
            if (main_valid_q && m_ready) begin
                main_valid_d = 1'b0;
            end
            // Skid only fills behind a full main, so it always refills main first.
            if (skid_valid_q && m_ready) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                if (!main_valid_q || m_ready) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                    main_last_d  = in_last;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in_data;
                    skid_last_d  = in_last;
                end
            end
        end
    end

    // NOTE: data registers are reset as well, so m_data reads 0 rather than X out of reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking only in clocked blocks; blocking here races other flops.
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
        end
    end

    assign m_valid    = main_valid_q;
    assign m_data     = main_data_q;
    assign m_last     = main_last_q;
    assign skid_valid = skid_valid_q;

endmodule

// File: rtl/sfifo_rd_stream.sv
// FIFO read-side controller: FSM, read-enable generation and burst framing.
// Optional SFIFO_RD_BEAT_CNT_EN adds a saturating handshake counter output beat_cnt.
module sfifo_rd_stream
    import sfifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic                  flush,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
`ifdef SFIFO_RD_BEAT_CNT_EN
    ,
    output logic [31:0]           beat_cnt
`endif
);

    localparam int               CNT_W    = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             skid_valid;
    logic             in_valid;
    logic             in_last;
    logic             stage_clear;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = RD_FLUSH;
        end else begin
            unique case (state_q)
                RD_IDLE:  if (en)         state_d = RD_RUN;
                RD_RUN:   if (!en)        state_d = RD_IDLE;
                RD_FLUSH: if (fifo_empty) state_d = RD_IDLE;
                default:                  state_d = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Gated by skid_valid instead of m_ready: the stage always has room for
    // the word read this cycle, and m_ready stays off the read path.
    assign fifo_rden = ((state_q == RD_RUN) && en && !flush && !fifo_empty && !skid_valid)
                     || ((state_q == RD_FLUSH) && !fifo_empty);

    assign in_valid    = fifo_rden && (state_q == RD_RUN);
    assign in_last     = (burst_cnt_q == LAST_CNT);
    assign stage_clear = flush || (state_q == RD_FLUSH);

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (stage_clear) begin
            burst_cnt_d = '0;
        end else if (in_valid) begin
            burst_cnt_d = in_last ? '0 : burst_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

    sfifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .arst_n     (arst_n),
        .clear      (stage_clear),
        .in_valid   (in_valid),
        .in_data    (fifo_rdata),
        .in_last    (in_last),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .skid_valid (skid_valid)
    );

    assign busy = (state_q != RD_IDLE) || m_valid || skid_valid;

`ifdef SFIFO_RD_BEAT_CNT_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (flush) begin
            beat_cnt_d = '0;
        end else if (m_valid && m_ready && (beat_cnt_q != 32'hFFFF_FFFF)) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
